// File: rtl/subleq_exec_ctrl_pkg.sv
// Shared word width, state encodings and types for the subleq execute controller.
// The SUBLEQ_IO_EN macro (checked in the top) enables the memory-mapped IO port at the all-ones address.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ST_FETCH_A
`define ST_FETCH_A 3'd0
`define ST_FETCH_B 3'd1
`define ST_FETCH_C 3'd2
`define ST_LOAD_A  3'd3
`define ST_LOAD_B  3'd4
`define ST_WRITE   3'd5
`define ST_HALT    3'd6
`endif

package subleq_exec_ctrl_pkg;
  localparam int W = `WORD_SIZE;

  typedef logic [W-1:0] word_t;

  typedef enum logic [2:0] {
    S_FETCH_A = `ST_FETCH_A,
    S_FETCH_B = `ST_FETCH_B,
    S_FETCH_C = `ST_FETCH_C,
    S_LOAD_A  = `ST_LOAD_A,
    S_LOAD_B  = `ST_LOAD_B,
    S_WRITE   = `ST_WRITE,
    S_HALT    = `ST_HALT
  } state_t;

  // Operand address that is redirected to the IO port when IO is enabled.
  localparam word_t IO_ADDR = '1;
endpackage

// File: rtl/subleq_exec_ctrl_if.sv
// Memory bus between the subleq execute controller (master) and a synchronous memory (slave).
interface subleq_exec_ctrl_if;
  import subleq_exec_ctrl_pkg::*;

  // No valid/ready: every cycle presents an address, read data returns exactly one cycle
  // later, and a write commits on the rising edge where mem_we is high.
  word_t mem_addr;
  word_t mem_data_in;
  word_t mem_data_out;
  logic  mem_we;

  modport master (
    output mem_addr,
    output mem_data_out,
    output mem_we,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr,
    input  mem_data_out,
    input  mem_we,
    output mem_data_in
  );
endinterface

// File: rtl/subleq_exec_ctrl_alu.sv
// Subleq arithmetic: wrapped difference b_val - a_val and the less-or-equal-zero flag.
module subleq_alu
  import subleq_exec_ctrl_pkg::*;
(
  input  word_t b_val,
  input  word_t a_val,
  output word_t res,
  output logic  leq
);
  assign res = b_val - a_val;
  // Sign bit of the wrapped result; overflow is deliberately not corrected.
  assign leq = (res == '0) || res[W-1];
endmodule

// File: rtl/subleq_exec_ctrl.sv
// Subleq sequencer/execute unit: fetches A,B,C, loads mem[A], mem[B], writes back and branches.
// Define SUBLEQ_IO_EN to map the all-ones operand address onto io_in / io_out.
module subleq_exec_ctrl
  import subleq_exec_ctrl_pkg::*;
#(
  parameter word_t RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      run,
  subleq_exec_ctrl_if.master        mem,
  output word_t                     pc,
  output logic                      halted,
  output state_t                    state
`ifdef SUBLEQ_IO_EN
  ,
  input  word_t                     io_in,
  output logic                      io_in_ack,
  output word_t                     io_out,
  output logic                      io_out_valid
`endif
);
  word_t a_reg, b_reg, c_reg, va;
  word_t res, pc_next;
  logic  leq, b_is_io, take_branch, halt_now;

  subleq_alu u_alu (
    .b_val (mem.mem_data_in),
    .a_val (va),
    .res   (res),
    .leq   (leq)
  );

`ifdef SUBLEQ_IO_EN
  logic a_is_io;
  assign a_is_io = (a_reg == IO_ADDR);
  assign b_is_io = (b_reg == IO_ADDR);
`else
  assign b_is_io = 1'b0;
`endif

  // An IO store never branches, so it can never halt either.
  assign take_branch = leq && !b_is_io;
  assign pc_next     = take_branch ? c_reg : pc + word_t'(3);
  assign halt_now    = take_branch && (c_reg == pc);

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= S_FETCH_A;
      pc    <= RESET_PC;
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      va    <= '0;
    end else begin
      case (state)
        S_FETCH_A: if (run) state <= S_FETCH_B;
        S_FETCH_B: begin
          a_reg <= mem.mem_data_in;
          state <= S_FETCH_C;
        end
        S_FETCH_C: begin
          b_reg <= mem.mem_data_in;
          state <= S_LOAD_A;
        end
        S_LOAD_A: begin
          c_reg <= mem.mem_data_in;
          state <= S_LOAD_B;
        end
        S_LOAD_B: begin
`ifdef SUBLEQ_IO_EN
          va <= a_is_io ? io_in : mem.mem_data_in;
`else
          va <= mem.mem_data_in;
`endif
          state <= S_WRITE;
        end
        S_WRITE: begin
          pc    <= pc_next;
          state <= halt_now ? S_HALT : S_FETCH_A;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH_A;
      endcase
    end
  end

  always_comb begin
    mem.mem_addr = pc;
    case (state)
      S_FETCH_A: mem.mem_addr = pc;
      S_FETCH_B: mem.mem_addr = pc + word_t'(1);
      S_FETCH_C: mem.mem_addr = pc + word_t'(2);
      S_LOAD_A:  mem.mem_addr = a_reg;
      S_LOAD_B:  mem.mem_addr = b_reg;
      S_WRITE:   mem.mem_addr = b_reg;
      default:   mem.mem_addr = pc;
    endcase
  end

  // Reset in the WRITE cycle must suppress the strobe before the edge commits it.
  assign mem.mem_we       = (state == S_WRITE) && !b_is_io && !areset;
  assign mem.mem_data_out = (state == S_WRITE) ? res : '0;
  assign halted           = (state == S_HALT);

`ifdef SUBLEQ_IO_EN
  assign io_in_ack    = (state == S_LOAD_B) && a_is_io && !areset;
  assign io_out_valid = (state == S_WRITE) && b_is_io && !areset;
  assign io_out       = io_out_valid ? va : '0;
`endif
endmodule

// File: tb/tb_subleq_exec_ctrl.sv
// Directed bench for subleq_exec_ctrl: two instances (RESET_PC 0 and 0xFFFE) on behavioural memories.
module tb_subleq_exec_ctrl;
  import subleq_exec_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic   rst0 = 1'b1, rst1 = 1'b1, run0 = 1'b0, run1 = 1'b0;
  word_t  pc0, pc1;
  logic   halted0, halted1;
  state_t st0, st1;

  logic  ld0_we = 1'b0, ld1_we = 1'b0;
  word_t ld0_addr = '0, ld1_addr = '0, ld0_data = '0, ld1_data = '0;
  word_t mem0 [0:(1<<W)-1];
  word_t mem1 [0:(1<<W)-1];

  subleq_exec_ctrl_if bus0 ();
  subleq_exec_ctrl_if bus1 ();

`ifdef SUBLEQ_IO_EN
  word_t io_in0 = '0, io_in1 = '0, io_out0, io_out1;
  logic  io_in_ack0, io_in_ack1, io_out_valid0, io_out_valid1;
`endif

  subleq_exec_ctrl #(.RESET_PC(16'h0000)) u_dut0 (
    .clk(clk), .areset(rst0), .run(run0), .mem(bus0.master),
    .pc(pc0), .halted(halted0), .state(st0)
`ifdef SUBLEQ_IO_EN
    , .io_in(io_in0), .io_in_ack(io_in_ack0), .io_out(io_out0), .io_out_valid(io_out_valid0)
`endif
  );

  subleq_exec_ctrl #(.RESET_PC(16'hFFFE)) u_dut1 (
    .clk(clk), .areset(rst1), .run(run1), .mem(bus1.master),
    .pc(pc1), .halted(halted1), .state(st1)
`ifdef SUBLEQ_IO_EN
    , .io_in(io_in1), .io_in_ack(io_in_ack1), .io_out(io_out1), .io_out_valid(io_out_valid1)
`endif
  );

  // Synchronous memories with a backdoor load port used only while the DUT is in reset.
  always @(posedge clk) begin
    if (ld0_we) mem0[ld0_addr] <= ld0_data;
    else if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_data_out;
    bus0.mem_data_in <= mem0[bus0.mem_addr];
  end

  always @(posedge clk) begin
    if (ld1_we) mem1[ld1_addr] <= ld1_data;
    else if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_data_out;
    bus1.mem_data_in <= mem1[bus1.mem_addr];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset(input int d);
    @(negedge clk);
    if (d == 0) begin rst0 = 1'b1; run0 = 1'b0; end
    else begin rst1 = 1'b1; run1 = 1'b0; end
    step(2);
  endtask

  task automatic poke(input int d, input word_t addr, input word_t data);
    if (d == 0) begin ld0_we = 1'b1; ld0_addr = addr; ld0_data = data; end
    else begin ld1_we = 1'b1; ld1_addr = addr; ld1_data = data; end
    @(negedge clk);
    ld0_we = 1'b0;
    ld1_we = 1'b0;
  endtask

  // Called at a negedge: this negedge is cycle 0 (FETCH_A) of the first instruction.
  task automatic go(input int d);
    if (d == 0) begin rst0 = 1'b0; run0 = 1'b1; end
    else begin rst1 = 1'b0; run1 = 1'b1; end
  endtask

  task automatic test_reset;
    hold_reset(0);
    checks++; if (bus0.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", bus0.mem_addr); end
    checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus0.mem_we); end
    checks++; if (halted0 !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted0); end
    checks++; if (bus0.mem_data_out !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", bus0.mem_data_out); end
    rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (st0 !== S_FETCH_A || bus0.mem_addr !== 16'h0000 || bus0.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL run_gate cycle %0d state %0d addr %h we %b want state 0 addr 0000 we 0", i, st0, bus0.mem_addr, bus0.mem_we);
      end
    end
  endtask

  task automatic test_not_taken;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 20); poke(0, 10, 3); poke(0, 11, 5);
    go(0);
    step(4);
    checks++; if (bus0.mem_we !== 1'b0 || bus0.mem_addr !== 16'd11) begin errors++; $display("FAIL nt_load_b addr %h we %b want 000b 0", bus0.mem_addr, bus0.mem_we); end
    step(1);
    checks++; if (bus0.mem_we !== 1'b1) begin errors++; $display("FAIL nt_we got %b want 1", bus0.mem_we); end
    checks++; if (bus0.mem_addr !== 16'd11) begin errors++; $display("FAIL nt_waddr got %h want 000b", bus0.mem_addr); end
    checks++; if (bus0.mem_data_out !== 16'd2) begin errors++; $display("FAIL nt_wdata got %h want 0002", bus0.mem_data_out); end
    step(1);
    run0 = 1'b0;
    checks++; if (bus0.mem_addr !== 16'd3 || pc0 !== 16'd3) begin errors++; $display("FAIL nt_next addr %h pc %h want 0003", bus0.mem_addr, pc0); end
    checks++; if (mem0[11] !== 16'd2) begin errors++; $display("FAIL nt_memory got %h want 0002", mem0[11]); end
  endtask

  task automatic test_taken;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 20); poke(0, 10, 5); poke(0, 11, 5);
    go(0);
    step(5);
    checks++; if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 16'd11 || bus0.mem_data_out !== 16'd0) begin
      errors++; $display("FAIL tk_write we %b addr %h data %h want 1 000b 0000", bus0.mem_we, bus0.mem_addr, bus0.mem_data_out); end
    step(1);
    run0 = 1'b0;
    checks++; if (bus0.mem_addr !== 16'd20 || pc0 !== 16'd20) begin errors++; $display("FAIL tk_next addr %h pc %h want 0014", bus0.mem_addr, pc0); end
    checks++; if (halted0 !== 1'b0) begin errors++; $display("FAIL tk_halted got %b want 0", halted0); end
  endtask

  task automatic test_signed_wrap;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 20); poke(0, 10, 1); poke(0, 11, 16'h8000);
    go(0);
    step(5);
    checks++; if (bus0.mem_we !== 1'b1 || bus0.mem_data_out !== 16'h7FFF) begin errors++; $display("FAIL sw_write we %b data %h want 1 7fff", bus0.mem_we, bus0.mem_data_out); end
    step(1);
    run0 = 1'b0;
    checks++; if (pc0 !== 16'd3 || bus0.mem_addr !== 16'd3) begin errors++; $display("FAIL sw_pc pc %h addr %h want 0003", pc0, bus0.mem_addr); end
  endtask

  task automatic test_pc_wrap;
    word_t exp_addr [6];
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'd10, 16'd11, 16'd11};
    hold_reset(1);
    poke(1, 16'hFFFE, 10); poke(1, 16'hFFFF, 11); poke(1, 0, 20); poke(1, 10, 3); poke(1, 11, 5);
    go(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus1.mem_addr !== exp_addr[i]) begin errors++; $display("FAIL pw_addr cycle %0d got %h want %h", i, bus1.mem_addr, exp_addr[i]); end
      if (i < 5) step(1);
    end
    checks++; if (bus1.mem_we !== 1'b1 || bus1.mem_data_out !== 16'd2) begin errors++; $display("FAIL pw_write we %b data %h want 1 0002", bus1.mem_we, bus1.mem_data_out); end
    step(1);
    run1 = 1'b0;
    checks++; if (pc1 !== 16'h0001 || bus1.mem_addr !== 16'h0001) begin errors++; $display("FAIL pw_pc pc %h addr %h want 0001", pc1, bus1.mem_addr); end
  endtask

  task automatic test_back_to_back;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 6); poke(0, 10, 3); poke(0, 11, 5);
    poke(0, 3, 12); poke(0, 4, 13); poke(0, 5, 0); poke(0, 12, 4); poke(0, 13, 1);
    go(0);
    step(6);
    checks++; if (st0 !== S_FETCH_A || bus0.mem_addr !== 16'd3) begin errors++; $display("FAIL b2b_fetch state %0d addr %h want 0 0003", st0, bus0.mem_addr); end
    step(1);
    checks++; if (bus0.mem_addr !== 16'd4) begin errors++; $display("FAIL b2b_nobubble addr %h want 0004", bus0.mem_addr); end
    step(4);
    checks++; if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 16'd13 || bus0.mem_data_out !== 16'hFFFD) begin
      errors++; $display("FAIL b2b_write we %b addr %h data %h want 1 000d fffd", bus0.mem_we, bus0.mem_addr, bus0.mem_data_out); end
    step(1);
    run0 = 1'b0;
    checks++; if (pc0 !== 16'd0 || halted0 !== 1'b0) begin errors++; $display("FAIL b2b_branch pc %h halted %b want 0000 0", pc0, halted0); end
  endtask

  task automatic test_halt;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 10); poke(0, 2, 0); poke(0, 10, 7);
    go(0);
    step(5);
    checks++; if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 16'd10 || bus0.mem_data_out !== 16'd0) begin
      errors++; $display("FAIL halt_write we %b addr %h data %h want 1 000a 0000", bus0.mem_we, bus0.mem_addr, bus0.mem_data_out); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (halted0 !== 1'b1 || bus0.mem_we !== 1'b0 || bus0.mem_addr !== 16'd0) begin
        errors++; $display("FAIL halt_hold cycle %0d halted %b we %b addr %h want 1 0 0000", i, halted0, bus0.mem_we, bus0.mem_addr); end
    end
    checks++; if (mem0[10] !== 16'd0) begin errors++; $display("FAIL halt_memory got %h want 0000", mem0[10]); end
    rst0 = 1'b1;
    run0 = 1'b0;
    step(1);
    checks++; if (halted0 !== 1'b0 || bus0.mem_addr !== 16'd0 || st0 !== S_FETCH_A) begin
      errors++; $display("FAIL halt_reset halted %b addr %h state %0d want 0 0000 0", halted0, bus0.mem_addr, st0); end
  endtask

  task automatic test_reset_mid_write;
    hold_reset(0);
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 20); poke(0, 10, 3); poke(0, 11, 5);
    go(0);
    step(5);
    rst0 = 1'b1;
    #1;
    checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL rmw_we got %b want 0", bus0.mem_we); end
    step(1);
    run0 = 1'b0;
    checks++; if (mem0[11] !== 16'd5 || pc0 !== 16'd0) begin errors++; $display("FAIL rmw_state mem %h pc %h want 0005 0000", mem0[11], pc0); end
  endtask

`ifdef SUBLEQ_IO_EN
  task automatic test_io;
    hold_reset(0);
    poke(0, 0, 16'h20); poke(0, 1, 16'hFFFF); poke(0, 2, 16'h30); poke(0, 16'h20, 16'h41);
    go(0);
    step(4);
    checks++; if (io_out_valid0 !== 1'b0) begin errors++; $display("FAIL io_early valid %b want 0", io_out_valid0); end
    step(1);
    checks++; if (io_out_valid0 !== 1'b1 || io_out0 !== 16'h41 || bus0.mem_we !== 1'b0) begin
      errors++; $display("FAIL io_out valid %b data %h we %b want 1 0041 0", io_out_valid0, io_out0, bus0.mem_we); end
    step(1);
    run0 = 1'b0;
    checks++; if (io_out_valid0 !== 1'b0 || pc0 !== 16'd3) begin errors++; $display("FAIL io_out_end valid %b pc %h want 0 0003", io_out_valid0, pc0); end
    hold_reset(0);
    poke(0, 0, 16'hFFFF); poke(0, 1, 16'h21); poke(0, 2, 16'h30); poke(0, 16'h21, 9);
    io_in0 = 16'd5;
    go(0);
    step(4);
    checks++; if (io_in_ack0 !== 1'b1) begin errors++; $display("FAIL io_in_ack got %b want 1", io_in_ack0); end
    step(1);
    checks++; if (io_in_ack0 !== 1'b0 || bus0.mem_we !== 1'b1 || bus0.mem_data_out !== 16'd4 || bus0.mem_addr !== 16'h21) begin
      errors++; $display("FAIL io_in_write ack %b we %b data %h addr %h want 0 1 0004 0021", io_in_ack0, bus0.mem_we, bus0.mem_data_out, bus0.mem_addr); end
    step(1);
    run0 = 1'b0;
    checks++; if (pc0 !== 16'd3) begin errors++; $display("FAIL io_in_pc got %h want 0003", pc0); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_not_taken();
    test_taken();
    test_signed_wrap();
    test_pc_wrap();
    test_back_to_back();
    test_halt();
    test_reset_mid_write();
`ifdef SUBLEQ_IO_EN
    test_io();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
